// File: rtl/sys_ctrl_cmd_pkg.sv
// Shared definitions for the command parser: opcodes, default widths and FSM state encoding.
package sys_ctrl_cmd_pkg;

    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefDataWidth = 8;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StTxHold
    } state_e;

endpackage

// File: rtl/sys_ctrl_timeout_cnt.sv
// Inter-byte timeout counter for the command parser; present only with SYS_CTRL_CMD_TIMEOUT_EN.
`ifdef SYS_CTRL_CMD_TIMEOUT_EN
module sys_ctrl_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/sys_ctrl_cmd.sv
// Byte-serial command parser feeding register-file strobes and returning read data to UART TX.
// Optional inter-byte timeout enabled by defining SYS_CTRL_CMD_TIMEOUT_EN.
module sys_ctrl_cmd
    import sys_ctrl_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
`ifdef SYS_CTRL_CMD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  ERR_FLAG
);

    state_e                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    timeout;

`ifdef SYS_CTRL_CMD_TIMEOUT_EN
    logic frame_active;

    // Only mid-frame states wait on RX; elsewhere the counter is held cleared.
    assign frame_active = (state_q == StWrAddr) || (state_q == StWrData) ||
                          (state_q == StRdAddr);

    sys_ctrl_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .clr_i    (RX_D_VLD || !frame_active),
        .en_i     (frame_active),
        .expire_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;

        case (state_q)
            StIdle: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
                        state_d = StWrAddr;
                    end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
                        state_d = StRdAddr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrAddr: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = StWrData;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrData: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = StIdle;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdAddr: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = StRdWait;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdWait: begin
                // Stray RX bytes while a read is outstanding are dropped and flagged.
                err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    tx_vld_d  = 1'b1;
                    state_d   = StTxHold;
                end
            end
            StTxHold: begin
                err_d = RX_D_VLD;
                if (!TX_BUSY) begin
                    tx_vld_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign ERR_FLAG  = err_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Self-checking bench for sys_ctrl_cmd: frame-level reference model, register-file model and
// directed frames. Timeout scenario runs only with SYS_CTRL_CMD_TIMEOUT_EN.
module tb_sys_ctrl_cmd;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       WrEn, RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic       ERR_FLAG;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    sys_ctrl_cmd #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (8)
`ifdef SYS_CTRL_CMD_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_BUSY      (TX_BUSY),
        .ERR_FLAG     (ERR_FLAG)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Register file: reset contents are 0xA0+index, read data one cycle after RdEn.
    logic [7:0] regs [16];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'hA0 + 8'(i);
            RdData_Valid <= 1'b0;
            RdData       <= 8'h00;
        end else begin
            RdData_Valid <= RdEn;
            if (RdEn) RdData <= regs[Address];
            if (WrEn) regs[Address] <= WrData;
        end
    end

    // Frame-level reference: bytes collect into a frame buffer; complete frames become strobes.
    logic [7:0] frame [$];
    logic       m_wr = 0, m_rd = 0, m_err = 0, m_txv = 0;
    logic [3:0] m_addr = 0;
    logic [7:0] m_wd = 0, m_txd = 0;
    logic       rd_wait = 0, tx_hold = 0;
    int         idle = 0;
    localparam int TimeoutCycles = 16;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_wr <= 0; m_rd <= 0; m_err <= 0; m_txv <= 0;
            m_addr <= 0; m_wd <= 0; m_txd <= 0;
            rd_wait <= 0; tx_hold <= 0; idle <= 0;
            frame.delete();
        end else begin
            m_wr <= 0; m_rd <= 0; m_err <= 0;
            if (rd_wait || tx_hold) begin
                if (RX_D_VLD) m_err <= 1;
                if (rd_wait && RdData_Valid) begin
                    m_txd <= RdData; m_txv <= 1; rd_wait <= 0; tx_hold <= 1;
                end else if (tx_hold && !TX_BUSY) begin
                    m_txv <= 0; tx_hold <= 0;
                end
            end else if (RX_D_VLD) begin
                idle <= 0;
                frame.push_back(RX_P_DATA);
                if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
                    m_err <= 1;
                    frame.delete();
                end else begin
                    if (frame.size() == 2) m_addr <= frame[1][3:0];
                    if (frame[0] == 8'hAA && frame.size() == 3) begin
                        m_wd <= frame[2]; m_wr <= 1; frame.delete();
                    end else if (frame[0] == 8'hBB && frame.size() == 2) begin
                        m_rd <= 1; rd_wait <= 1; frame.delete();
                    end
                end
            end
`ifdef SYS_CTRL_CMD_TIMEOUT_EN
            else if (frame.size() != 0) begin
                if (idle + 1 == TimeoutCycles) begin
                    m_err <= 1; idle <= 0; frame.delete();
                end else begin
                    idle <= idle + 1;
                end
            end
`endif
        end
    end

    // Per-cycle compare plus event capture for the directed checks.
    int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_cnt = 0;
    logic [3:0] last_wr_addr = 0;
    logic [7:0] last_wr_data = 0, last_tx = 0;

    always @(negedge CLK) begin
        chk("WrEn", 32'(WrEn), 32'(m_wr));
        chk("RdEn", 32'(RdEn), 32'(m_rd));
        chk("ERR_FLAG", 32'(ERR_FLAG), 32'(m_err));
        chk("Address", 32'(Address), 32'(m_addr));
        chk("WrData", 32'(WrData), 32'(m_wd));
        chk("TX_D_VLD", 32'(TX_D_VLD), 32'(m_txv));
        chk("TX_P_DATA", 32'(TX_P_DATA), 32'(m_txd));
        chk("wr_rd_excl", 32'(WrEn & RdEn), 32'd0);
        if (WrEn) begin
            wr_cnt <= wr_cnt + 1; last_wr_addr <= Address; last_wr_data <= WrData;
        end
        if (RdEn) rd_cnt <= rd_cnt + 1;
        if (ERR_FLAG) err_cnt <= err_cnt + 1;
        if (TX_D_VLD && !TX_BUSY) begin
            tx_cnt <= tx_cnt + 1; last_tx <= TX_P_DATA;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_cnt < target && n < 30) begin
            tick();
            n++;
        end
        chk("tx_done", 32'(tx_cnt), 32'(target));
    endtask

    int e0, w0, t0;

    initial begin
        #2 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_WrEn", 32'(WrEn), 32'd0);
        chk("rst_TX_D_VLD", 32'(TX_D_VLD), 32'd0);
        chk("rst_Address", 32'(Address), 32'd0);
        RST = 1'b1;
        tick();

        // Plain write, then a write whose address byte has upper bits set.
        send(8'hAA); send(8'h05); send(8'h3C);
        repeat (3) tick();
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("t1_addr", 32'(last_wr_addr), 32'h5);
        chk("t1_data", 32'(last_wr_data), 32'h3C);
        chk("t1_no_tx", 32'(tx_cnt), 32'd0);
        chk("t1_no_err", 32'(err_cnt), 32'd0);
        send(8'hAA); send(8'hF6); send(8'h12);
        repeat (2) tick();
        chk("t1_hi_addr", 32'(last_wr_addr), 32'h6);

        // Write then read back.
        send(8'hAA); send(8'h02); send(8'h81);
        send(8'hBB); send(8'h02);
        wait_tx(1);
        chk("t2_rd_data", 32'(last_tx), 32'h81);
        chk("t2_rd_cnt", 32'(rd_cnt), 32'd1);

        // Response held while the transmitter is busy.
        TX_BUSY = 1'b1;
        send(8'hBB); send(8'h05);
        for (int n = 0; n < 20 && !TX_D_VLD; n++) tick();
        chk("t3_txv_up", 32'(TX_D_VLD), 32'd1);
        t0 = tx_cnt;
        repeat (5) tick();
        chk("t3_txv_held", 32'(TX_D_VLD), 32'd1);
        chk("t3_txd_held", 32'(TX_P_DATA), 32'h3C);
        chk("t3_not_taken", 32'(tx_cnt), 32'(t0));
        TX_BUSY = 1'b0;
        tick();
        chk("t3_txv_drop", 32'(TX_D_VLD), 32'd0);
        chk("t3_last_tx", 32'(last_tx), 32'h3C);

        // Unknown opcode, then FSM must still accept a write.
        e0 = err_cnt;
        send(8'h55);
        repeat (2) tick();
        chk("t4_bad_op_err", 32'(err_cnt), 32'(e0 + 1));
        send(8'hAA); send(8'h0A); send(8'h5A);
        repeat (2) tick();
        chk("t4_after_err_addr", 32'(last_wr_addr), 32'hA);
        chk("t4_after_err_data", 32'(last_wr_data), 32'h5A);

        // Stray byte during RD_WAIT.
        e0 = err_cnt;
        t0 = tx_cnt;
        send(8'hBB); send(8'h07); send(8'h11);
        wait_tx(t0 + 1);
        chk("t4_rdwait_err", 32'(err_cnt), 32'(e0 + 1));
        chk("t4_rdwait_data", 32'(last_tx), 32'hA7);

        // Back-to-back: write's last byte followed immediately by a read opcode.
        t0 = tx_cnt;
        send(8'hAA); send(8'h03); send(8'h44); send(8'hBB); send(8'h03);
        wait_tx(t0 + 1);
        chk("b2b_rd_data", 32'(last_tx), 32'h44);

        // Reset mid-frame discards the partial write; register file is back at reset values.
        w0 = wr_cnt;
        send(8'hAA); send(8'h09);
        RST = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        tick();
        t0 = tx_cnt;
        send(8'hBB); send(8'h09);
        wait_tx(t0 + 1);
        chk("t5_no_wr", 32'(wr_cnt), 32'(w0));
        chk("t5_rd_reset_val", 32'(last_tx), 32'hA9);

`ifdef SYS_CTRL_CMD_TIMEOUT_EN
        e0 = err_cnt;
        w0 = wr_cnt;
        send(8'hAA);
        repeat (18) tick();
        chk("t6_timeout_err", 32'(err_cnt), 32'(e0 + 1));
        chk("t6_no_wr", 32'(wr_cnt), 32'(w0));
        send(8'hAA); send(8'h01); send(8'hFF);
        repeat (2) tick();
        chk("t6_wr_addr", 32'(last_wr_addr), 32'h1);
        chk("t6_wr_data", 32'(last_wr_data), 32'hFF);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
Command-parser FSM between the RX data synchronizer and the register file.
- Decodes byte-serial frames from the UART receive path into register-file write and read strobes.
- Returns read data to the UART transmit path over a valid/busy handshake.
- Runs in the reference clock domain, same domain as the register file.

Parameters:
ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used.
DATA_WIDTH, 8, byte width of RX, TX and register data.
CMD_WR, 8'hAA, opcode for register write: frame is opcode, addr, data.
CMD_RD, 8'hBB, opcode for register read: frame is opcode, addr.
TIMEOUT_CYCLES, 1024, inter-byte timeout; used only when the optional feature is compiled in.

Ports:
CLK  input  1  reference clock
RST  input  1  reset, asynchronous, active-low
RX_P_DATA  input  DATA_WIDTH  received byte, valid when RX_D_VLD=1
RX_D_VLD  input  1  single-cycle strobe, one per received byte
RdData  input  DATA_WIDTH  register-file read data
RdData_Valid  input  1  register-file read-data strobe
WrEn  output  1  register-file write strobe
RdEn  output  1  register-file read strobe
Address  output  ADDR_WIDTH  register-file address
WrData  output  DATA_WIDTH  register-file write data
TX_P_DATA  output  DATA_WIDTH  byte to transmit
TX_D_VLD  output  1  TX request, held until accepted
TX_BUSY  input  1  transmitter busy; a transfer completes when TX_D_VLD=1 and TX_BUSY=0
ERR_FLAG  output  1  single-cycle pulse on a protocol error

Behaviour:
- All outputs are registered.
- Reset values: WrEn=0, RdEn=0, Address=0, WrData=0, TX_P_DATA=0, TX_D_VLD=0, ERR_FLAG=0, state=IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD.
- IDLE:
  - RX_D_VLD with CMD_WR -> WR_ADDR.
  - RX_D_VLD with CMD_RD -> RD_ADDR.
  - Any other byte -> ERR_FLAG pulses next cycle; stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch Address=RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA. Upper address bits are ignored.
- WR_DATA: on RX_D_VLD, WrData=RX_P_DATA and WrEn=1 for exactly one cycle, starting the cycle after the strobe -> IDLE.
- RD_ADDR: on RX_D_VLD, latch Address and assert RdEn=1 for exactly one cycle, starting the cycle after the strobe -> RD_WAIT.
- RD_WAIT: on RdData_Valid, TX_P_DATA=RdData and TX_D_VLD=1 from the next cycle -> TX_HOLD.
- TX_HOLD:
  - TX_D_VLD and TX_P_DATA stay stable while TX_BUSY=1.
  - On the first cycle with TX_BUSY=0, the transfer is accepted; TX_D_VLD drops next cycle -> IDLE.
- WrEn and RdEn are never high together.
- Address holds its last value between commands.
- RX_D_VLD arriving in RD_WAIT or TX_HOLD: the byte is dropped, ERR_FLAG pulses, state is unchanged.
- Latencies:
  - Last frame byte strobe to WrEn/RdEn: 1 cycle.
  - RdData_Valid to TX_D_VLD: 1 cycle.
- Back-to-back frames:
  - A new opcode is accepted in IDLE on the cycle immediately after returning to IDLE.
  - A write frame's final byte and the next opcode may arrive on consecutive cycles; both are handled.
- Asynchronous reset mid-frame: the FSM returns to IDLE and all strobes clear immediately; the partial frame is discarded.

Optional Feature:
Macro SYS_CTRL_CMD_TIMEOUT_EN.
- Defined:
  - An inter-byte counter clears on each accepted byte in WR_ADDR, WR_DATA or RD_ADDR, and increments otherwise in those states.
  - On reaching TIMEOUT_CYCLES-1 the FSM -> IDLE, ERR_FLAG pulses, and no WrEn/RdEn is issued.
  - The counter does not run in IDLE, RD_WAIT or TX_HOLD.
- Not defined: no counter exists; a partial frame waits indefinitely.

Decomposition:
- Shared package: opcode constants CMD_WR/CMD_RD, the state enum typedef, and default ADDR_WIDTH/DATA_WIDTH, shared with the register file and the top level.
- No sub-module, except when the timeout is enabled: then the counter is a natural small sub-module, sys_ctrl_timeout_cnt (clear, enable, expire outputs).

Test Plan:
1. Write frame: RX bytes AA,05,3C -> one-cycle WrEn with Address=5, WrData=3C; no TX_D_VLD; no ERR_FLAG.
2. Read frame: AA,02,81 then BB,02, regfile model returns 81 one cycle after RdEn -> TX_D_VLD=1 with TX_P_DATA=81.
3. Hold TX_BUSY=1 for 5 cycles during the read response -> TX_D_VLD and TX_P_DATA stay stable throughout, then drop one cycle after TX_BUSY=0.
4. Errors:
   - Unknown opcode 0x55 -> one ERR_FLAG pulse, state stays IDLE.
   - Send BB,07, then inject byte 11 in RD_WAIT -> ERR_FLAG pulses and the read still completes.
5. Reset: assert RST after AA,09 -> WrEn never asserts; after release, BB,09 reads back the reset value.
6. With SYS_CTRL_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send AA then idle 16 cycles -> ERR_FLAG pulses and state returns to IDLE; a following AA,01,FF writes correctly.
